// File: rtl/iob_cpu_bus_arb.sv
// iob_cpu_bus_arb: two-master (ibus/dbus) to one-slave IOb arbiter, one outstanding transaction; define IOB_CPU_BUS_ARB_RR_EN for round-robin tie-break (default: dbus wins ties)
module iob_cpu_bus_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int REQ_W = 1 + ADDR_W + DATA_W + DATA_W / 8,
  localparam int RESP_W = DATA_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQ_W-1:0]  ibus_req,
  output logic [RESP_W-1:0] ibus_resp,
  input  logic [REQ_W-1:0]  dbus_req,
  output logic [RESP_W-1:0] dbus_resp,
  output logic [REQ_W-1:0]  m_req,
  input  logic [RESP_W-1:0] m_resp,
  output logic [1:0]        grant
);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [REQ_W-1:0] NO_STRB = {{(REQ_W-STRB_W){1'b1}}, {STRB_W{1'b0}}};
  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_t;
  state_t r_state, w_next;
  logic r_last_d;
  logic w_i_v, w_d_v, w_ready, w_tie_d;
  assign w_i_v = ibus_req[REQ_W-1];
  assign w_d_v = dbus_req[REQ_W-1];
  assign w_ready = m_resp[0];
`ifdef IOB_CPU_BUS_ARB_RR_EN
  assign w_tie_d = ~r_last_d;
`else
  // last_owner is still tracked here but can never change the outcome
  assign w_tie_d = 1'b1 | r_last_d;
`endif
  // next state: grant from IDLE only, always return to IDLE after a completion
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE)
      w_next = (w_i_v && w_d_v) ? (w_tie_d ? OWN_D : OWN_I) : w_d_v ? OWN_D : w_i_v ? OWN_I : IDLE;
    else if (w_ready)
      w_next = IDLE;
  end
  // owner's request passes through, responses routed only to the owner on ready
  always_comb begin
    m_req = (r_state == OWN_I) ? (ibus_req & NO_STRB) : (r_state == OWN_D) ? dbus_req : '0;
    ibus_resp = (r_state == OWN_I && w_ready) ? m_resp : '0;
    dbus_resp = (r_state == OWN_D && w_ready) ? m_resp : '0;
    grant = {r_state == OWN_D, r_state == OWN_I};
  end
  // state register and last-owner tracking, updated on every grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last_d <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next != IDLE) r_last_d <= (w_next == OWN_D);
    end
  end
endmodule
